bimodal_btb_predictor: RTL and testbench
========================================

# bimodal_btb_predictor

Parametrised dynamic branch predictor for the IF stage. It pairs a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. It predicts the next fetch PC combinationally from `pc_i` and learns from resolved-branch feedback sent back by EX. It replaces the static not-taken predictor, and keeps that behaviour as a selectable mode.

## Interface
Parameters:
- `BTB_ENTRIES`, 64: number of BTB entries; power of two, at least 2.
- `CTR_W`, 2: direction counter width, 1..4.
- `PRED_MODE`, `BP_BIMODAL`: prediction mode, one of `BP_STATIC_NT`, `BP_BTB_TAKEN`, `BP_BIMODAL`.
- Derived values:
  - `IDX_W = $clog2(BTB_ENTRIES)`
  - `TAG_W = 30 - IDX_W`

Ports (clock and reset first):
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `pc_i` in 32 (`rv32i_word`): current fetch PC.
- `pc_pred_o` out 32: predicted next fetch PC.
- `pred_taken_o` out 1: prediction is a taken redirect.
- `insn_valid_i` in 1: EX feedback is valid this cycle.
- `insn_pc_i` in 32: PC of the resolved control-transfer instruction.
- `insn_is_br_i` in 1: the resolved instruction was taken.
- `insn_target_i` in 32: resolved target address.

## Operation
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[31:IDX_W+2]`
  - bits [1:0] are ignored.
- Per-entry state: `valid` (1), `tag` (`TAG_W`), `target` (32), `ctr` (`CTR_W`).
- Lookup is combinational. `hit` = the indexed entry is valid and its tag equals the tag of `pc_i`.
- Prediction by mode:
  - `BP_STATIC_NT`: `pred_taken_o` = 0 and `pc_pred_o` = `pc_i + 4` always. Updates are ignored and the state stays in its reset value.
  - `BP_BTB_TAKEN`: `pred_taken_o` = `hit`.
  - `BP_BIMODAL`: `pred_taken_o` = `hit` and the counter MSB is set.
- `pc_pred_o` = the entry's `target` when `pred_taken_o` is set, else `pc_i + 4`. The add is 32-bit modulo, so `0xFFFFFFFC` gives `0x00000000`.
- Update happens only when `insn_valid_i` is high. It uses the index and tag of `insn_pc_i`.
- Update on an entry hit with taken feedback:
  - `target` is set to `insn_target_i`.
  - `ctr` increments, saturating at all-ones.
- Update on an entry hit with not-taken feedback:
  - `ctr` decrements, saturating at 0.
  - `valid` stays set.
- Update on a miss with taken feedback:
  - The entry is allocated or overwritten: `valid` = 1, new tag, `target` = `insn_target_i`.
  - `ctr` is set to weakly taken, which is MSB = 1 with all other bits 0.
- Update on a miss with not-taken feedback: no state change.
- Counter width edge case: when `CTR_W` = 1, the counter is the taken bit itself.
- Reset, while `rst_i` is low at a rising edge:
  - All `valid` bits clear.
  - All `ctr` values go to weakly not-taken: MSB = 0, all other bits 1 (value 0 when `CTR_W` = 1).
  - `tag` and `target` are not reset.
- Outputs during and after reset: with all `valid` clear, `pred_taken_o` = 0 and `pc_pred_o` = `pc_i + 4`.
- Reset mid-operation: reset takes priority over a concurrent update, and that update is discarded.

## Timing
- Prediction latency is 0 cycles: the outputs are purely combinational from `pc_i` and the registered state.
- Update latency is 1 cycle: feedback presented in cycle N affects lookups from cycle N+1 onward.
- Same-index lookup and update in one cycle: the lookup sees the pre-update state. There is no bypass.
- No handshake. `insn_valid_i` is a single-cycle pulse per resolved instruction, at most one per cycle.
- The EX feedback inputs are ignored when `insn_valid_i` is low.

## Structure
- Add `bp_mode_e` (`BP_STATIC_NT`, `BP_BTB_TAKEN`, `BP_BIMODAL`) to `rv32i_types`, next to `rv32i_word`.
- Add the helper functions `ctr_weak_taken(CTR_W)` and `ctr_weak_nt(CTR_W)` to the same package.
- Sub-module `bp_sat_counter`:
  - Parametrised by `CTR_W`.
  - Inputs: `inc`, `dec`, `load`, `load_val`.
  - Purely combinational next-state logic.
- The storage arrays are flops inside `bimodal_btb_predictor`, one `bp_sat_counter` instance per update path.
- Only the updated entry changes in any cycle.

## Test plan
All scenarios use `BTB_ENTRIES`=16 and `CTR_W`=2 (`IDX_W`=4), with `BP_BIMODAL` unless stated otherwise.
- **Reset:** hold `rst_i`=0 for 2 cycles, release, drive `pc_i`=`0x100` → `pred_taken_o`=0, `pc_pred_o`=`0x104`.
- **Allocation:** feedback pc=`0x100`, taken, target=`0x200` → from the next cycle, `pc_i`=`0x100` gives `pred_taken_o`=1, `pc_pred_o`=`0x200`.
- **Hysteresis:** from the state above, one not-taken feedback takes ctr 10→01, and a lookup predicts `0x104`. Two taken feedbacks then take ctr 01→10→11, and a lookup predicts `0x200`.
- **Saturation and aliasing:**
  - Three taken feedbacks at ctr=11 keep ctr=11.
  - A lookup at `pc_i`=`0x140` (same index, different tag) is a miss and gives `0x144`.
  - Taken feedback at `0x140` with target `0x300` evicts the old entry, and `0x100` then misses.
- **Same-cycle update:** present a lookup of `0x100` and allocation feedback for `0x100` in the same cycle → that cycle gives `0x104`, and the next cycle gives the target.
- **Mode and wrap:**
  - `BP_STATIC_NT`: any feedback, then `pc_i`=`0x100` → `0x104`.
  - `BP_BTB_TAKEN`: with ctr=00 but a valid hit → predicts the target.
  - `pc_i`=`0xFFFFFFFC` on a miss → `0x00000000`.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types plus branch-predictor mode and counter helpers
// Purpose : common package for the fetch stage.
// Contents: rv32i_word, bp_mode_e, and the counter seed helpers
//           ctr_weak_taken / ctr_weak_nt.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [1:0] {
      BP_STATIC_NT = 2'd0,
      BP_BTB_TAKEN = 2'd1,
      BP_BIMODAL   = 2'd2
   } bp_mode_e;

   // Weakly taken: MSB set, all lower bits clear. The result is returned in 4 bits;
   // callers keep the low w bits.
   function automatic logic [3:0] ctr_weak_taken(input int unsigned w);
      return 4'(1 << (w - 1));
   endfunction

   // Weakly not-taken: MSB clear, all lower bits set. This gives 0 when w is 1.
   function automatic logic [3:0] ctr_weak_nt(input int unsigned w);
      return 4'((1 << (w - 1)) - 1);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational next-state logic for a saturating direction counter
// Purpose: computes the next value of one CTR_W-bit saturating counter.
// Ports  : ctr      - current counter value
//          inc      - count up, holding at all-ones
//          dec      - count down, holding at zero
//          load     - replace the value with load_val (wins over inc/dec)
//          load_val - value used by load
//          ctr_next - resulting counter value
module bp_sat_counter #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [CTR_W-1:0] load_val,
   output logic [CTR_W-1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (load) begin
         ctr_next = load_val;
      end else if (inc && !(&ctr)) begin
         ctr_next = ctr + 1'b1;
      end else if (dec && (|ctr)) begin
         ctr_next = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/bimodal_btb_predictor.sv
// rtl/bimodal_btb_predictor.sv - direct-mapped BTB with per-entry saturating direction counters
// Purpose: predicts the next fetch PC combinationally and learns from EX feedback
//          one cycle later. There is no bypass, so a same-cycle lookup sees the old state.
// Ports  : clk_i, rst_i (sync, active-low)
//          pc_i -> pc_pred_o, pred_taken_o : combinational lookup
//          insn_valid_i, insn_pc_i, insn_is_br_i (taken), insn_target_i : EX feedback
module bimodal_btb_predictor
   import rv32i_types::*;
#(
   parameter int       BTB_ENTRIES = 64,
   parameter int       CTR_W       = 2,
   parameter bp_mode_e PRED_MODE   = BP_BIMODAL
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  rv32i_word pc_i,
   output rv32i_word pc_pred_o,
   output logic      pred_taken_o,
   input  logic      insn_valid_i,
   input  rv32i_word insn_pc_i,
   input  logic      insn_is_br_i,
   input  rv32i_word insn_target_i
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   rv32i_word              target_q [BTB_ENTRIES];
   logic [CTR_W-1:0]       ctr_q    [BTB_ENTRIES];

   // Lookup path
   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             l_hit;

   assign l_idx = pc_i[IDX_W+1:2];
   assign l_tag = pc_i[31:IDX_W+2];
   assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

   always_comb begin
      pred_taken_o = 1'b0;
      case (PRED_MODE)
         BP_BTB_TAKEN: pred_taken_o = l_hit;
         BP_BIMODAL:   pred_taken_o = l_hit && ctr_q[l_idx][CTR_W-1];
         default:      pred_taken_o = 1'b0;
      endcase
   end

   assign pc_pred_o = pred_taken_o ? target_q[l_idx] : (pc_i + 32'd4);

   // Update path
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             upd_en;
   logic [CTR_W-1:0] u_ctr_next;

   assign u_idx  = insn_pc_i[IDX_W+1:2];
   assign u_tag  = insn_pc_i[31:IDX_W+2];
   assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   // The static mode keeps the state at its reset value, so updates are blocked here.
   assign upd_en = insn_valid_i && (PRED_MODE != BP_STATIC_NT);

   // The low PC bits never take part in indexing or tag matching.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_i[1:0], insn_pc_i[1:0]};

   bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .ctr      (ctr_q[u_idx]),
      .inc      (u_hit && insn_is_br_i),
      .dec      (u_hit && !insn_is_br_i),
      .load     (!u_hit && insn_is_br_i),
      .load_val (CTR_WT),
      .ctr_next (u_ctr_next)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            ctr_q[i] <= CTR_WNT;
         end
      end else if (upd_en) begin
         if (insn_is_br_i) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= u_ctr_next;
         end else if (u_hit) begin
            ctr_q[u_idx]   <= u_ctr_next;
         end
      end
   end

   // Tag and target are not reset. A taken update writes them on both allocation
   // and hit. On a hit the tag is unchanged, so rewriting it is harmless.
   always_ff @(posedge clk_i) begin
      if (rst_i && upd_en && insn_is_br_i) begin
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= insn_target_i;
      end
   end

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// tb/tb_bimodal_btb_predictor.sv - scoreboard bench running the three predictor modes side by side
module tb_bimodal_btb_predictor;
   import rv32i_types::*;

   logic      clk = 1'b0;
   logic      rst;
   rv32i_word pc;
   logic      fb_valid;
   rv32i_word fb_pc;
   logic      fb_taken;
   rv32i_word fb_target;

   rv32i_word pp_st, pp_btb, pp_bim;
   logic      pt_st, pt_btb, pt_bim;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int unsigned dut;
      logic [31:0] pc;
      logic        tk;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bimodal_btb_predictor #(.BTB_ENTRIES(16), .CTR_W(2), .PRED_MODE(BP_STATIC_NT)) dut_st (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_pred_o(pp_st), .pred_taken_o(pt_st),
      .insn_valid_i(fb_valid), .insn_pc_i(fb_pc), .insn_is_br_i(fb_taken), .insn_target_i(fb_target));

   bimodal_btb_predictor #(.BTB_ENTRIES(16), .CTR_W(2), .PRED_MODE(BP_BTB_TAKEN)) dut_btb (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_pred_o(pp_btb), .pred_taken_o(pt_btb),
      .insn_valid_i(fb_valid), .insn_pc_i(fb_pc), .insn_is_br_i(fb_taken), .insn_target_i(fb_target));

   bimodal_btb_predictor #(.BTB_ENTRIES(16), .CTR_W(2), .PRED_MODE(BP_BIMODAL)) dut_bim (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_pred_o(pp_bim), .pred_taken_o(pt_bim),
      .insn_valid_i(fb_valid), .insn_pc_i(fb_pc), .insn_is_br_i(fb_taken), .insn_target_i(fb_target));

   task automatic tick();
      @(posedge clk);
      #1;
      fb_valid = 1'b0;
   endtask

   task automatic push(string nm, int unsigned d, logic [31:0] a, logic [31:0] e);
      exp_t x;
      x.name = nm;
      x.dut  = d;
      x.pc   = e;
      x.tk   = (e != a + 32'd4);
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t      e;
      rv32i_word o_pc;
      logic      o_tk;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0:       begin o_pc = pp_st;  o_tk = pt_st;  end
            1:       begin o_pc = pp_btb; o_tk = pt_btb; end
            default: begin o_pc = pp_bim; o_tk = pt_bim; end
         endcase
         checks++;
         assert (o_pc === e.pc) else begin
            errors++;
            $error("FAIL %s.pc dut=%0d observed=%h expected=%h", e.name, e.dut, o_pc, e.pc);
         end
         checks++;
         assert (o_tk === e.tk) else begin
            errors++;
            $error("FAIL %s.taken dut=%0d observed=%b expected=%b", e.name, e.dut, o_tk, e.tk);
         end
      end
   endtask

   // Expected next-PC per mode: static, btb-taken, bimodal
   task automatic look(string nm, logic [31:0] a, logic [31:0] e_st, logic [31:0] e_btb,
                       logic [31:0] e_bim);
      pc = a;
      push(nm, 0, a, e_st);
      push(nm, 1, a, e_btb);
      push(nm, 2, a, e_bim);
      #2;
      drain();
   endtask

   task automatic fb(logic [31:0] a, logic t, logic [31:0] tgt);
      fb_valid  = 1'b1;
      fb_pc     = a;
      fb_taken  = t;
      fb_target = tgt;
      tick();
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0; fb_valid = 1'b0; fb_pc = 32'h0; fb_taken = 1'b0; fb_target = 32'h0;
      tick();
      tick();
      rst = 1'b1;
      look("reset", 32'h100, 32'h104, 32'h104, 32'h104);

      fb(32'h100, 1'b1, 32'h200);                               // alloc, ctr=10
      look("alloc", 32'h100, 32'h104, 32'h200, 32'h200);

      fb(32'h100, 1'b0, 32'h0);                                 // ctr=01
      look("hyst_nt1", 32'h100, 32'h104, 32'h200, 32'h104);
      fb(32'h100, 1'b0, 32'h0);                                 // ctr=00
      look("ctr00_hit", 32'h100, 32'h104, 32'h200, 32'h104);
      fb(32'h100, 1'b1, 32'h200);                               // ctr=01
      look("hyst_t1", 32'h100, 32'h104, 32'h200, 32'h104);
      fb(32'h100, 1'b1, 32'h200);                               // ctr=10
      look("hyst_t2", 32'h100, 32'h104, 32'h200, 32'h200);
      fb(32'h100, 1'b1, 32'h200);                               // ctr=11
      look("hyst_t3", 32'h100, 32'h104, 32'h200, 32'h200);

      for (int i = 0; i < 3; i++) fb(32'h100, 1'b1, 32'h200);  // held at 11
      look("sat_hold", 32'h100, 32'h104, 32'h200, 32'h200);
      fb(32'h100, 1'b0, 32'h0);                                 // ctr=10
      look("sat_nt1", 32'h100, 32'h104, 32'h200, 32'h200);
      fb(32'h100, 1'b0, 32'h0);                                 // ctr=01
      look("sat_nt2", 32'h100, 32'h104, 32'h200, 32'h104);

      look("alias_miss", 32'h140, 32'h144, 32'h144, 32'h144);
      fb(32'h140, 1'b1, 32'h300);                               // evicts 0x100
      look("alias_new", 32'h140, 32'h144, 32'h300, 32'h300);
      look("alias_old", 32'h100, 32'h104, 32'h104, 32'h104);
      fb(32'h100, 1'b0, 32'h0);                                 // miss not-taken: no change
      look("miss_nt", 32'h140, 32'h144, 32'h300, 32'h300);

      fb_valid = 1'b1; fb_pc = 32'h100; fb_taken = 1'b1; fb_target = 32'h200;
      look("same_cyc", 32'h100, 32'h104, 32'h104, 32'h104);
      tick();
      look("same_next", 32'h100, 32'h104, 32'h200, 32'h200);

      look("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);

      fb(32'h008, 1'b1, 32'h800);
      look("idx2", 32'h008, 32'h00C, 32'h800, 32'h800);

      rst = 1'b0;                                               // reset wins over update
      fb_valid = 1'b1; fb_pc = 32'h00C; fb_taken = 1'b1; fb_target = 32'h900;
      tick();
      look("in_reset", 32'h00C, 32'h010, 32'h010, 32'h010);
      rst = 1'b1;
      look("rst_drop", 32'h00C, 32'h010, 32'h010, 32'h010);
      look("rst_clr", 32'h100, 32'h104, 32'h104, 32'h104);
      look("rst_clr2", 32'h008, 32'h00C, 32'h00C, 32'h00C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
